// File: rtl/serv_uart_rx.sv
// rtl/serv_uart_rx.sv - UART receiver with byte FIFO and Wishbone regs; optional even parity via SERV_UART_RX_PARITY_EN
module serv_uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        i_rx,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERV_UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

    // Line synchronizer and edge history
    logic sync1_q, sync2_q, rx_prev_q;
    logic rx_s;

    // Receiver FSM state
    rx_state_t   state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        push_q;
    logic        ferr_set_q;
    logic        perr_set_q;
    logic        par_bad_q;
    logic        cnt_expired;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          not_empty, full, pop, do_push, ovr_set;

    // Bus and flags
    logic        wb_req, rd_data_req, wr_status;
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;
    logic        irq_q, irq_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        perr_q, perr_d;
    logic        unused_dat;

    assign rx_s        = sync2_q;
    assign cnt_expired = (cnt_q <= 16'd1);
    assign unused_dat  = ^{i_wb_dat[31:4], i_wb_dat[0]};

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high at reset
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= i_rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // Frame receiver: samples mid-bit, emits one-cycle push / error strobes
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            par_bad_q  <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_BIT;
                    end
                end
                S_START: begin
                    if (cnt_expired) begin
                        if (!rx_s) begin
                            state_q   <= S_DATA;
                            cnt_q     <= FULL_BIT;
                            bit_idx_q <= '0;
                            par_bad_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_expired) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= FULL_BIT;
                        if (bit_idx_q == 3'd7) begin
`ifdef SERV_UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`ifdef SERV_UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_expired) begin
                        if (rx_s != ^shift_q) begin
                            perr_set_q <= 1'b1;
                            par_bad_q  <= 1'b1;
                        end
                        state_q <= S_STOP;
                        cnt_q   <= FULL_BIT;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_expired) begin
                        if (rx_s) begin
                            push_q  <= !par_bad_q;
                            state_q <= S_IDLE;
                        end else begin
                            ferr_set_q <= 1'b1;
                            state_q    <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus decode and FIFO push/pop arbitration; a pop frees room for a simultaneous push
    always_comb begin
        wb_req      = i_wb_cyc & i_wb_stb & ~ack_q;
        rd_data_req = wb_req & ~i_wb_we & ~i_wb_adr;
        wr_status   = wb_req & i_wb_we & i_wb_adr;
        not_empty   = (count_q != '0);
        full        = (count_q == DEPTH_C);
        pop         = rd_data_req & not_empty;
        do_push     = push_q & (~full | pop);
        ovr_set     = push_q & full & ~pop;
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sticky flags (set wins over write-1-clear), ack, read data and irq next-state
    always_comb begin
        ovr_d  = ovr_set    | (ovr_q  & ~(wr_status & i_wb_dat[1]));
        ferr_d = ferr_set_q | (ferr_q & ~(wr_status & i_wb_dat[2]));
        perr_d = perr_set_q | (perr_q & ~(wr_status & i_wb_dat[3]));
        ack_d  = wb_req;
        irq_d  = not_empty;
        rdt_d  = '0;
        if (wb_req && !i_wb_we) begin
            if (i_wb_adr) begin
                rdt_d = {28'b0, perr_q, ferr_q, ovr_q, not_empty};
            end else if (not_empty) begin
                rdt_d = {23'b0, 1'b1, mem_q[rd_ptr_q]};
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge wb_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Registered FIFO control, flags and bus outputs
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            irq_q    <= irq_d;
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_irq    = irq_q;
endmodule
